// File: rtl/gamma_sel_ctrl_if.sv
// Operator key / gamma select bundle for gamma_sel_ctrl.
// slave: the controller (consumes raw keys, drives select outputs).
// master: the board side / bench (drives raw keys, observes outputs).
interface gamma_sel_ctrl_if;
   logic       iKEY_UP;
   logic       iKEY_DN;
   logic [9:0] oSEL;
   logic [3:0] oLEVEL;
   logic       oCHANGE;

   modport slave  (input iKEY_UP, iKEY_DN, output oSEL, oLEVEL, oCHANGE);
   modport master (output iKEY_UP, iKEY_DN, input oSEL, oLEVEL, oCHANGE);
endinterface

// File: rtl/gamma_sel_ctrl.sv
// gamma_sel_ctrl: debounces the gamma up/down push buttons (active-low) and
// keeps a gamma level 0..9 (gamma 0.6..1.5), emitting a registered one-hot
// select vector, the level, and a one-cycle change pulse.
// Build option: define GAMMA_SEL_WRAP_EN to make the level wrap 9->0 / 0->9
// instead of saturating.
module gamma_sel_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned RESET_LEVEL     = 4
) (
   input logic           iCLK,
   input logic           iRST_N,
   gamma_sel_ctrl_if.slave bus
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]     LVL_RST  = 4'(RESET_LEVEL);
   localparam logic [3:0]     LVL_MAX  = 4'd9;

   // Select bit ordering puts gamma 1.0 on bit0, the rest ascending.
   function automatic logic [9:0] onehot(input logic [3:0] lvl);
      logic [9:0] v;
      v = '0;
      if (lvl < 4'd4)       v[lvl + 4'd1] = 1'b1;
      else if (lvl == 4'd4) v[0]          = 1'b1;
      else                  v[lvl]        = 1'b1;
      return v;
   endfunction

   // index 0 = up key, index 1 = down key
   logic [1:0]    raw;
   logic [1:0]    sync1, sync2;
   logic [1:0]    stable, stable_d;
   logic [CW-1:0] cnt [2];
   logic [1:0]    press;

   logic [3:0]    level, level_nxt;
   logic [9:0]    sel;
   logic          change;

   assign raw = {bus.iKEY_DN, bus.iKEY_UP};

   // Two-flop synchroniser per key; idle level is released (high).
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level only after it has persisted long enough.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         stable   <= '1;
         stable_d <= '1;
         for (int unsigned k = 0; k < 2; k++) cnt[k] <= '0;
      end else begin
         stable_d <= stable;
         for (int unsigned k = 0; k < 2; k++) begin
            if (sync2[k] == stable[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_LAST) begin
               stable[k] <= sync2[k];
               cnt[k]    <= '0;
            end else begin
               cnt[k] <= cnt[k] + CW'(1);
            end
         end
      end
   end

   // A press is the debounced 1->0 transition; release is ignored.
   assign press = stable_d & ~stable;

   // Next level: single-key events only; simultaneous presses cancel.
   always_comb begin
      level_nxt = level;
      if (press[0] && !press[1]) begin
         if (level == LVL_MAX) begin
`ifdef GAMMA_SEL_WRAP_EN
            level_nxt = 4'd0;
`else
            level_nxt = LVL_MAX;
`endif
         end else begin
            level_nxt = level + 4'd1;
         end
      end else if (press[1] && !press[0]) begin
         if (level == 4'd0) begin
`ifdef GAMMA_SEL_WRAP_EN
            level_nxt = LVL_MAX;
`else
            level_nxt = 4'd0;
`endif
         end else begin
            level_nxt = level - 4'd1;
         end
      end
   end

   // Level, select vector and change pulse all update on the same edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         level  <= LVL_RST;
         sel    <= onehot(LVL_RST);
         change <= 1'b0;
      end else begin
         level  <= level_nxt;
         sel    <= onehot(level_nxt);
         change <= (level_nxt != level);
      end
   end

   assign bus.oLEVEL  = level;
   assign bus.oSEL    = sel;
   assign bus.oCHANGE = change;

endmodule

// File: tb/tb_gamma_sel_ctrl.sv
// Bench for gamma_sel_ctrl with DEBOUNCE_CYCLES=4: directed key sequences,
// a raw-domain behavioural model compared every cycle, and literal checks.
module tb_gamma_sel_ctrl;

   localparam int D = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   gamma_sel_ctrl_if bif ();

   gamma_sel_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_LEVEL(4)) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // gamma*10 carried by each select bit
   int   gamma10 [10] = '{10, 6, 7, 8, 9, 11, 12, 13, 14, 15};
   int   m_lvl = 4;
   logic exp_chg = 1'b0;
   bit   ev_up [8];
   bit   ev_dn [8];
   int   cyc = 0;
   int   run_val [2] = '{1, 1};
   int   run_len [2] = '{0, 0};
   int   stb     [2] = '{1, 1};

   function automatic logic [9:0] exp_sel(input int lvl);
      logic [9:0] v;
      v = '0;
      for (int b = 0; b < 10; b++) if (gamma10[b] == 60 / 10 + lvl) v[b] = 1'b1;
      return v;
   endfunction

   // Model: a raw run of the opposite level lasting D samples flips the key;
   // a flip to pressed updates the level three edges after its last sample.
   always @(posedge clk) begin
      int raw [2];
      int nl;
      cyc++;
      if (!rst_n) begin
         m_lvl   = 4;
         exp_chg = 1'b0;
         for (int i = 0; i < 8; i++) begin ev_up[i] = 0; ev_dn[i] = 0; end
         for (int k = 0; k < 2; k++) begin run_val[k] = 1; run_len[k] = 0; stb[k] = 1; end
      end else begin
         exp_chg = 1'b0;
         if (ev_up[cyc % 8] != ev_dn[cyc % 8]) begin
            nl = ev_up[cyc % 8] ? m_lvl + 1 : m_lvl - 1;
`ifdef GAMMA_SEL_WRAP_EN
            if (nl > 9) nl = 0;
            if (nl < 0) nl = 9;
`else
            if (nl > 9) nl = 9;
            if (nl < 0) nl = 0;
`endif
            exp_chg = (nl != m_lvl);
            m_lvl   = nl;
         end
         ev_up[cyc % 8] = 0;
         ev_dn[cyc % 8] = 0;
         raw[0] = int'(bif.iKEY_UP);
         raw[1] = int'(bif.iKEY_DN);
         for (int k = 0; k < 2; k++) begin
            if (raw[k] == run_val[k]) run_len[k]++;
            else begin run_val[k] = raw[k]; run_len[k] = 1; end
            if (run_val[k] != stb[k] && run_len[k] == D) begin
               stb[k] = run_val[k];
               if (stb[k] == 0) begin
                  if (k == 0) ev_up[(cyc + 3) % 8] = 1;
                  else        ev_dn[(cyc + 3) % 8] = 1;
               end
            end
         end
      end
      #1;
      check("model_level",  32'(bif.oLEVEL),  32'(m_lvl));
      check("model_sel",    32'(bif.oSEL),    32'(exp_sel(m_lvl)));
      check("model_change", 32'(bif.oCHANGE), 32'(exp_chg));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Hold the selected keys low for n cycles, count change pulses seen.
   task automatic hold(input bit up, input bit dn, input int n, output int pulses);
      bif.iKEY_UP = ~up;
      bif.iKEY_DN = ~dn;
      pulses = 0;
      repeat (n) begin
         tick();
         if (bif.oCHANGE === 1'b1) pulses++;
      end
      bif.iKEY_UP = 1'b1;
      bif.iKEY_DN = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int p;
      int total;
      bif.iKEY_UP = 1'b1;
      bif.iKEY_DN = 1'b1;
      idle(3);
      check("reset_level",  32'(bif.oLEVEL),  32'd4);
      check("reset_sel",    32'(bif.oSEL),    32'b0000000001);
      check("reset_change", 32'(bif.oCHANGE), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // UP held: update exactly at the 7th edge after driving low (N+6)
      bif.iKEY_UP = 1'b0;
      idle(6);
      check("up_before_level", 32'(bif.oLEVEL), 32'd4);
      tick();
      check("up_level",  32'(bif.oLEVEL),  32'd5);
      check("up_sel",    32'(bif.oSEL),    32'b0000100000);
      check("up_change", 32'(bif.oCHANGE), 32'd1);
      tick();
      check("up_pulse_end", 32'(bif.oCHANGE), 32'd0);
      hold(1, 0, 12, p);
      check("up_no_repeat", 32'(p), 32'd0);
      idle(10);
      check("up_hold_level", 32'(bif.oLEVEL), 32'd5);

      // DN glitch shorter than the debounce window, then a bouncy press
      do_reset();
      hold(0, 1, 3, p);
      idle(10);
      check("glitch_level", 32'(bif.oLEVEL), 32'd4);
      hold(0, 1, 2, p);
      idle(1);
      hold(0, 1, 10, p);
      idle(10);
      check("bounce_pulses", 32'(p), 32'd1);
      check("bounce_level",  32'(bif.oLEVEL), 32'd3);
      check("bounce_sel",    32'(bif.oSEL),   32'b0000010000);

      // Six UP presses from reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         hold(1, 0, 8, p);
         idle(10);
         check("six_up_level", 32'(bif.oLEVEL), 32'(5 + i));
      end
      check("six_up_sel9", 32'(bif.oSEL), 32'b1000000000);
      hold(1, 0, 8, p);
      idle(10);
`ifdef GAMMA_SEL_WRAP_EN
      check("wrap_level",  32'(bif.oLEVEL), 32'd0);
      check("wrap_sel",    32'(bif.oSEL),   32'b0000000010);
      check("wrap_pulses", 32'(p),          32'd1);
      hold(0, 1, 8, p);
      idle(10);
      check("wrap_dn_level", 32'(bif.oLEVEL), 32'd9);
`else
      check("sat_level",  32'(bif.oLEVEL), 32'd9);
      check("sat_sel",    32'(bif.oSEL),   32'b1000000000);
      check("sat_pulses", 32'(p),          32'd0);
`endif

      // DN saturation at 0 (saturating build) / general walk down
      do_reset();
      total = 0;
      for (int i = 0; i < 4; i++) begin
         hold(0, 1, 8, p);
         total += p;
         idle(10);
      end
      check("dn_walk_level",  32'(bif.oLEVEL), 32'd0);
      check("dn_walk_sel",    32'(bif.oSEL),   32'b0000000010);
      check("dn_walk_pulses", 32'(total),      32'd4);

      // Both keys together: cancelled
      do_reset();
      hold(1, 1, 10, p);
      idle(10);
      check("both_level",  32'(bif.oLEVEL), 32'd4);
      check("both_pulses", 32'(p),          32'd0);

      // Reset in the middle of a debounce at level 7, key kept held
      do_reset();
      for (int i = 0; i < 3; i++) begin
         hold(1, 0, 8, p);
         idle(10);
      end
      check("pre_rst_level", 32'(bif.oLEVEL), 32'd7);
      bif.iKEY_UP = 1'b0;
      idle(3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_level", 32'(bif.oLEVEL), 32'd4);
      check("mid_rst_sel",   32'(bif.oSEL),   32'b0000000001);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      check("held_rst_wait", 32'(bif.oLEVEL), 32'd4);
      tick();
      check("held_rst_level",  32'(bif.oLEVEL),  32'd5);
      check("held_rst_change", 32'(bif.oCHANGE), 32'd1);
      hold(1, 0, 10, p);
      check("held_rst_once", 32'(p), 32'd0);
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
